// File: rtl/ex3_to_bin_serial_if.sv
// Digit-in / result-out handshake bundle for the excess-3 to binary decoder.
// The slave modport is the decoder; the master modport is its environment
// (digit source plus result consumer).
interface ex3_to_bin_serial_if #(
  parameter int OUT_W = 14
);
  // Digit stream (source -> decoder)
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_code;
  logic             in_last;
  // Result stream (decoder -> consumer)
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_bin;
  logic             out_err;
  logic [2:0]       out_ndig;

  modport slave (
    input  in_valid, in_code, in_last, out_ready,
    output in_ready, out_valid, out_bin, out_err, out_ndig
  );

  modport master (
    output in_valid, in_code, in_last, out_ready,
    input  in_ready, out_valid, out_bin, out_err, out_ndig
  );
endinterface

// File: rtl/ex3_to_bin_serial.sv
// Serial excess-3 to binary decoder. Accepts MSD-first excess-3 digits,
// accumulates acc*10 + digit, and presents one result per frame. A frame
// ends on in_last or on the NDIGITS-th digit. Illegal codes count as zero
// and raise a sticky error that travels with the frame's result.
// OUT_W must be wide enough for 10^NDIGITS - 1, so the accumulator never
// overflows.
module ex3_to_bin_serial #(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 14
) (
  input  logic                clk,
  input  logic                rst,
  ex3_to_bin_serial_if.slave  bus
);

  typedef enum logic {ACC, OUT} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] out_bin_q, out_bin_d;
  logic             out_err_q, out_err_d;
  logic [2:0]       out_ndig_q, out_ndig_d;

  logic             in_ready;
  logic             accept;
  logic             illegal;
  logic [3:0]       digit;
  logic [OUT_W-1:0] acc_next;
  logic [2:0]       cnt_inc;
  logic             terminal;

  // Digit-path datapath: decode, accumulate, and frame-end detection.
  assign in_ready = (state_q == ACC) && !rst;
  assign accept   = bus.in_valid && in_ready;
  assign illegal  = (bus.in_code < 4'd3) || (bus.in_code > 4'd12);
  assign digit    = illegal ? 4'd0 : (bus.in_code - 4'd3);
  assign acc_next = acc_q * OUT_W'(10) + OUT_W'(digit);
  assign cnt_inc  = cnt_q + 3'd1;
  assign terminal = bus.in_last || (cnt_inc == 3'(NDIGITS));

  // Next-state and register-update logic for the ACC/OUT controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    out_bin_d  = out_bin_q;
    out_err_d  = out_err_q;
    out_ndig_d = out_ndig_q;
    unique case (state_q)
      ACC: begin
        if (accept) begin
          if (terminal) begin
            state_d    = OUT;
            out_bin_d  = acc_next;
            out_err_d  = err_q || illegal;
            out_ndig_d = cnt_inc;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_inc;
            err_d = err_q || illegal;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      out_bin_q  <= '0;
      out_err_q  <= 1'b0;
      out_ndig_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      out_bin_q  <= out_bin_d;
      out_err_q  <= out_err_d;
      out_ndig_q <= out_ndig_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_bin   = out_bin_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_ndig  = out_ndig_q;

endmodule

// File: doc/ex3_to_bin_serial.md
Name: ex3_to_bin_serial

Overview:
- Inverse of the team's binary-to-excess-3 encoder.
- Accepts a stream of excess-3 coded decimal digits, most significant first, over a valid/ready handshake.
- Validates each code and accumulates the decoded value into a binary result (acc*10 + digit).
- Presents the result on an output valid/ready handshake. Sits between the excess-3 digit source and binary arithmetic logic.

Parameters:
- NDIGITS, 4, maximum digits per frame (1..7).
- OUT_W, 14, result width; must satisfy 2^OUT_W > 10^NDIGITS - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_code/in_last are valid.
- in_ready  output  1  block can accept a digit.
- in_code  input  4  excess-3 digit; legal codes are 3..12.
- in_last  input  1  final digit of the frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_bin  output  OUT_W  binary value of the frame.
- out_err  output  1  at least one illegal code in the frame.
- out_ndig  output  3  number of digits accepted in the frame (1..NDIGITS).

Behaviour:
- States: ACC (collecting digits) and OUT (holding the result). Reset state is ACC.
- Reset values: out_valid 0, out_bin 0, out_err 0, out_ndig 0, accumulator 0, count 0.
- in_ready is 0 while rst is high. Otherwise in_ready = (state == ACC).
- rst asserted mid-frame or in OUT discards everything. Partial frames are not emitted.
- A digit is accepted on a clk edge where in_valid & in_ready.
- Digit decode: d = in_code - 3.
  - If in_code < 3 or in_code > 12: d = 0 and the sticky err flag is set.
- On each accept: acc <= acc*10 + d (computed at OUT_W bits, no overflow by parameter rule), count <= count + 1.
- Frame termination: the accepted digit has in_last = 1, or it is the NDIGITS-th digit (count + 1 == NDIGITS).
  - An NDIGITS-th digit without in_last still terminates the frame. This is not an error.
  - Any following digits start a new frame.
- On the terminating accept, the next state is OUT. Registered on that same edge:
  - out_bin = final acc
  - out_err = sticky err, including the current digit
  - out_ndig = count + 1
- Latency: out_valid rises the cycle after the terminating digit is accepted.
- OUT state:
  - out_valid = 1; out_bin, out_err and out_ndig are held stable until the handshake.
  - in_ready = 0, so back-pressure is applied upstream.
- On out_valid & out_ready: the next state is ACC; acc, count and err clear; out_valid drops the next cycle.
  - out_bin, out_err and out_ndig may hold their last values while out_valid = 0.
- No overlap: at least one cycle of in_ready = 0 between frames. Throughput is at most 1 digit/cycle within a frame.
- in_valid without in_ready has no effect. in_code may change freely while in_ready = 0.
- A single-digit frame (in_last on the first digit) is legal: out_ndig = 1.

Test Plan:
- Reset then frame codes 4,5,6,7 (in_last on 7), in_valid held high → out_valid one cycle after 4th accept; out_bin = 1234, out_err = 0, out_ndig = 4.
- Frame codes 12,3 (in_last on 3) → out_bin = 90, out_ndig = 2. Then a frame with single code 8 and in_last → out_bin = 5, out_ndig = 1.
- Frame codes 5,15,6 (in_last on 6) → out_err = 1, out_bin = 203, out_ndig = 3. The next clean frame 9 (in_last) → out_err = 0, out_bin = 6.
- Five codes 4,4,4,4,4 with in_last never set → first result out_bin = 1111, out_ndig = 4. The 5th digit waits for in_ready, then starts a new frame.
- Back-pressure: hold out_ready = 0 for 10 cycles in OUT → out_valid stays 1, outputs stable, in_ready = 0, offered digits not consumed. Then out_ready = 1 → return to ACC.
- Assert rst after 2 digits of a frame → no out_valid. Post-reset frame 3 (in_last) → out_bin = 0, out_err = 0, out_ndig = 1.
